// File: rtl/cr_sa_core_param_pkg.sv
// -----------------------------------------------------------------------------
// cr_sa_paramPKG
// Shared constants and types for the statistics-accumulator core.
//   SA_N_CNT / SA_CNT_W / SA_N_EVT / SA_SEL_W : default geometry of the core
//   sa_mode_e                                 : per-counter overflow behaviour
//   sa_cnt_cfg_t                              : one counter's configuration as
//                                               the stats regfile packs it
// -----------------------------------------------------------------------------
package cr_sa_paramPKG;

  localparam int SA_N_CNT = 64;
  localparam int SA_CNT_W = 50;
  localparam int SA_N_EVT = 512;
  localparam int SA_SEL_W = 9;

  typedef enum logic {
    SA_WRAP = 1'b0,
    SA_SAT  = 1'b1
  } sa_mode_e;

  typedef struct packed {
    logic [SA_SEL_W-1:0] sel;
    logic                en;
    sa_mode_e            sat;
  } sa_cnt_cfg_t;

endpackage

// File: rtl/cr_sa_core_param_counter.sv
// -----------------------------------------------------------------------------
// cr_sa_counter
// One live statistics counter with sticky overflow and a snapshot copy.
//   clk, rst  : core clock, synchronous active-high reset
//   inc       : count one event this cycle
//   clr       : restart the live counter (at inc, so a coincident event is kept)
//   snap      : copy the pre-update live value and overflow flag into the
//               snapshot registers
//   sat       : 1 = saturate at all-ones, 0 = wrap to zero
//   count, snapshot, ovf, snap_ovf : registered state
// -----------------------------------------------------------------------------
module cr_sa_counter
  import cr_sa_paramPKG::*;
#(
  parameter int CNT_W = SA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  input  logic             sat,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snapshot,
  output logic             ovf,
  output logic             snap_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_snapshot;
  logic             r_ovf;
  logic             r_snap_ovf;
  sa_mode_e         w_mode;

  assign w_mode = sa_mode_e'(sat);

  // Live counter, sticky overflow and snapshot capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= CNT_ZERO;
      r_snapshot <= CNT_ZERO;
      r_ovf      <= 1'b0;
      r_snap_ovf <= 1'b0;
    end else begin
      // Snapshot takes the value from before this cycle's clear/increment,
      // so snap+clear together loses no event.
      if (snap) begin
        r_snapshot <= r_count;
        r_snap_ovf <= r_ovf;
      end

      if (clr) begin
        r_count <= {{(CNT_W-1){1'b0}}, inc};
        r_ovf   <= 1'b0;
      end else if (inc) begin
        if (r_count != CNT_MAX) begin
          r_count <= r_count + CNT_ONE;
        end else begin
          r_ovf <= 1'b1;
          case (w_mode)
            SA_SAT:  r_count <= CNT_MAX;
            SA_WRAP: r_count <= CNT_ZERO;
            default: r_count <= CNT_ZERO;
          endcase
        end
      end
    end
  end

  assign count    = r_count;
  assign snapshot = r_snapshot;
  assign ovf      = r_ovf;
  assign snap_ovf = r_snap_ovf;

endmodule

// File: rtl/cr_sa_core_param.sv
// -----------------------------------------------------------------------------
// cr_sa_core_param
// Parametrised statistics-accumulator core: N_CNT counters, each selecting one
// bit of a concatenated event bus, with global snapshot and live clear.
//   clk, rst           : core clock, synchronous active-high reset
//   stat_events        : concatenated single-cycle event pulses
//   cfg_sel            : per-counter event index, counter i at [i*SEL_W +: SEL_W]
//   cfg_en, cfg_sat    : per-counter enable and saturate(1)/wrap(0) mode
//   regs_sa_snap       : single-cycle snapshot request
//   regs_sa_clear_live : single-cycle live clear
//   sa_count, sa_snapshot, sa_ovf, sa_snap_ovf : per-counter state
//   sa_snap_vld        : pulse when the snapshot registers have been updated
// Events, snap and clear share one register stage so their relative timing is
// preserved; an event is visible on sa_count two cycles after it is presented.
// -----------------------------------------------------------------------------
module cr_sa_core_param
  import cr_sa_paramPKG::*;
#(
  parameter int N_CNT = SA_N_CNT,
  parameter int CNT_W = SA_CNT_W,
  parameter int N_EVT = SA_N_EVT,
  parameter int SEL_W = SA_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_EVT-1:0]       stat_events,
  input  logic [N_CNT*SEL_W-1:0] cfg_sel,
  input  logic [N_CNT-1:0]       cfg_en,
  input  logic [N_CNT-1:0]       cfg_sat,
  input  logic                   regs_sa_snap,
  input  logic                   regs_sa_clear_live,
  output logic [N_CNT*CNT_W-1:0] sa_count,
  output logic [N_CNT*CNT_W-1:0] sa_snapshot,
  output logic [N_CNT-1:0]       sa_ovf,
  output logic [N_CNT-1:0]       sa_snap_ovf,
  output logic                   sa_snap_vld
);

  logic [N_EVT-1:0] r_evt_q;
  logic             r_snap_q;
  logic             r_clr_q;
  logic             r_snap_vld;

  // Stage 1: register events together with the snap and clear requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_q    <= {N_EVT{1'b0}};
      r_snap_q   <= 1'b0;
      r_clr_q    <= 1'b0;
      r_snap_vld <= 1'b0;
    end else begin
      r_evt_q    <= stat_events;
      r_snap_q   <= regs_sa_snap;
      r_clr_q    <= regs_sa_clear_live;
      // Snapshot registers load on the same edge, so the strobe lines up.
      r_snap_vld <= r_snap_q;
    end
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    logic [SEL_W-1:0] w_sel;
    logic             w_inc;

    assign w_sel = cfg_sel[g*SEL_W +: SEL_W];

    // Event mux: a selector beyond the bus never counts.
    always_comb begin
      w_inc = 1'b0;
      if (32'(w_sel) < N_EVT) begin
        w_inc = cfg_en[g] & r_evt_q[w_sel];
      end else begin
        w_inc = 1'b0;
      end
    end

    cr_sa_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (w_inc),
      .clr      (r_clr_q),
      .snap     (r_snap_q),
      .sat      (cfg_sat[g]),
      .count    (sa_count[g*CNT_W +: CNT_W]),
      .snapshot (sa_snapshot[g*CNT_W +: CNT_W]),
      .ovf      (sa_ovf[g]),
      .snap_ovf (sa_snap_ovf[g])
    );
  end

  assign sa_snap_vld = r_snap_vld;

endmodule

// File: tb/tb_cr_sa_core_param.sv
// -----------------------------------------------------------------------------
// tb_cr_sa_core_param
// Directed bench for cr_sa_core_param with a small geometry (8 counters of
// 8 bits, 40-bit event bus, 6-bit selectors so out-of-range selectors exist).
// A behavioural model tracks every counter as an integer total and is compared
// against the DUT on every falling edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_cr_sa_core_param;

  localparam int N_CNT = 8;
  localparam int CNT_W = 8;
  localparam int N_EVT = 40;
  localparam int SEL_W = 6;
  localparam longint MAXV = (64'd1 << CNT_W) - 64'd1;

  logic                   clk;
  logic                   rst;
  logic [N_EVT-1:0]       stat_events;
  logic [N_CNT*SEL_W-1:0] cfg_sel;
  logic [N_CNT-1:0]       cfg_en;
  logic [N_CNT-1:0]       cfg_sat;
  logic                   regs_sa_snap;
  logic                   regs_sa_clear_live;
  logic [N_CNT*CNT_W-1:0] sa_count;
  logic [N_CNT*CNT_W-1:0] sa_snapshot;
  logic [N_CNT-1:0]       sa_ovf;
  logic [N_CNT-1:0]       sa_snap_ovf;
  logic                   sa_snap_vld;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  cr_sa_core_param #(
    .N_CNT (N_CNT),
    .CNT_W (CNT_W),
    .N_EVT (N_EVT),
    .SEL_W (SEL_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stat_events        (stat_events),
    .cfg_sel            (cfg_sel),
    .cfg_en             (cfg_en),
    .cfg_sat            (cfg_sat),
    .regs_sa_snap       (regs_sa_snap),
    .regs_sa_clear_live (regs_sa_clear_live),
    .sa_count           (sa_count),
    .sa_snapshot        (sa_snapshot),
    .sa_ovf             (sa_ovf),
    .sa_snap_ovf        (sa_snap_ovf),
    .sa_snap_vld        (sa_snap_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N_EVT-1:0] m_evt;     // events presented one cycle ago
  bit               m_snap;
  bit               m_clr;
  bit               m_vld;
  longint           m_cnt  [N_CNT];
  longint           m_shot [N_CNT];
  bit               m_ovf  [N_CNT];
  bit               m_sovf [N_CNT];

  function automatic bit m_inc(int i);
    int sel;
    sel = int'(cfg_sel[i*SEL_W +: SEL_W]);
    if (!cfg_en[i] || sel >= N_EVT) return 1'b0;
    return m_evt[sel];
  endfunction

  function automatic longint nxt_cnt(longint c, bit inc, bit sat, bit clr);
    longint s;
    if (clr) return longint'(inc);
    s = c + longint'(inc);
    if (s > MAXV) return sat ? MAXV : s - (MAXV + 64'd1);
    return s;
  endfunction

  function automatic bit nxt_ovf(bit o, longint c, bit inc, bit clr);
    if (clr) return 1'b0;
    return o || (c + longint'(inc) > MAXV);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_evt  <= '0;
      m_snap <= 1'b0;
      m_clr  <= 1'b0;
      m_vld  <= 1'b0;
      for (int i = 0; i < N_CNT; i++) begin
        m_cnt[i]  <= 0;
        m_shot[i] <= 0;
        m_ovf[i]  <= 1'b0;
        m_sovf[i] <= 1'b0;
      end
    end else begin
      m_evt  <= stat_events;
      m_snap <= regs_sa_snap;
      m_clr  <= regs_sa_clear_live;
      m_vld  <= m_snap;
      for (int i = 0; i < N_CNT; i++) begin
        if (m_snap) begin
          m_shot[i] <= m_cnt[i];
          m_sovf[i] <= m_ovf[i];
        end
        m_cnt[i] <= nxt_cnt(m_cnt[i], m_inc(i), cfg_sat[i], m_clr);
        m_ovf[i] <= nxt_ovf(m_ovf[i], m_cnt[i], m_inc(i), m_clr);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N_CNT*CNT_W-1:0] e_cnt;
      logic [N_CNT*CNT_W-1:0] e_shot;
      logic [N_CNT-1:0]       e_ovf;
      logic [N_CNT-1:0]       e_sovf;
      for (int i = 0; i < N_CNT; i++) begin
        e_cnt[i*CNT_W +: CNT_W]  = m_cnt[i][CNT_W-1:0];
        e_shot[i*CNT_W +: CNT_W] = m_shot[i][CNT_W-1:0];
        e_ovf[i]  = m_ovf[i];
        e_sovf[i] = m_sovf[i];
      end
      check("model_count", 64'(sa_count), 64'(e_cnt));
      check("model_snapshot", 64'(sa_snapshot), 64'(e_shot));
      check("model_ovf", 64'(sa_ovf), 64'(e_ovf));
      check("model_snap_ovf", 64'(sa_snap_ovf), 64'(e_sovf));
      check("model_snap_vld", 64'(sa_snap_vld), 64'(m_vld));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int i, input int v);
    cfg_sel[i*SEL_W +: SEL_W] = SEL_W'(v);
  endtask

  function automatic logic [63:0] cnt_of(input int i);
    return 64'(sa_count[i*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [63:0] shot_of(input int i);
    return 64'(sa_snapshot[i*CNT_W +: CNT_W]);
  endfunction

  task automatic live_clear();
    regs_sa_clear_live = 1'b1;
    step();
    regs_sa_clear_live = 1'b0;
    step();
  endtask

  initial begin
    int total;
    bit b;

    rst = 1'b1;
    stat_events = '0;
    cfg_sel = '0;
    cfg_en = '0;
    cfg_sat = '0;
    regs_sa_snap = 1'b0;
    regs_sa_clear_live = 1'b0;

    // Reset for two cycles; outputs all zero.
    step();
    chk_en = 1'b1;
    step();
    check("rst_count", 64'(sa_count), 64'd0);
    check("rst_snapshot", 64'(sa_snapshot), 64'd0);
    check("rst_vld", 64'(sa_snap_vld), 64'd0);
    rst = 1'b0;
    repeat (3) step();

    // Latency: event presented now shows up two edges later.
    set_sel(0, 5);
    cfg_en[0] = 1'b1;
    stat_events[5] = 1'b1;
    step();
    stat_events = '0;
    check("lat_t1", cnt_of(0), 64'd0);
    step();
    check("lat_t2", cnt_of(0), 64'd1);

    // Saturate (counter 0) vs wrap (counter 1) on the same bit.
    set_sel(0, 0);
    set_sel(1, 0);
    cfg_en[1:0]  = 2'b11;
    cfg_sat[1:0] = 2'b01;
    live_clear();
    stat_events[0] = 1'b1;
    repeat (255) step();
    stat_events = '0;
    step();
    check("sw_full_c0", cnt_of(0), 64'd255);
    check("sw_full_c1", cnt_of(1), 64'd255);
    check("sw_full_ovf", 64'(sa_ovf[1:0]), 64'd0);
    stat_events[0] = 1'b1;
    step();
    stat_events = '0;
    step();
    check("sw_256_c0", cnt_of(0), 64'd255);
    check("sw_256_c1", cnt_of(1), 64'd0);
    check("sw_256_ovf", 64'(sa_ovf[1:0]), 64'd3);
    stat_events[0] = 1'b1;
    step();
    stat_events = '0;
    step();
    check("sw_257_c0", cnt_of(0), 64'd255);
    check("sw_257_c1", cnt_of(1), 64'd1);

    // Snap + clear + event in one cycle on counter 2.
    set_sel(2, 1);
    cfg_en[2] = 1'b1;
    stat_events[1] = 1'b1;
    repeat (100) step();
    stat_events = '0;
    step();
    check("sc_pre_c2", cnt_of(2), 64'd100);
    stat_events[1] = 1'b1;
    regs_sa_snap = 1'b1;
    regs_sa_clear_live = 1'b1;
    step();
    stat_events = '0;
    regs_sa_snap = 1'b0;
    regs_sa_clear_live = 1'b0;
    check("sc_vld_early", 64'(sa_snap_vld), 64'd0);
    step();
    check("sc_shot_c2", shot_of(2), 64'd100);
    check("sc_cnt_c2", cnt_of(2), 64'd1);
    check("sc_ovf_c0", 64'(sa_ovf[0]), 64'd0);
    check("sc_sovf_c0", 64'(sa_snap_ovf[0]), 64'd1);
    check("sc_vld", 64'(sa_snap_vld), 64'd1);
    step();
    check("sc_vld_drop", 64'(sa_snap_vld), 64'd0);

    // Out-of-range selector never counts; counter 2 keeps counting bit 1.
    set_sel(3, N_EVT + 3);
    cfg_en[3] = 1'b1;
    stat_events = '1;
    repeat (50) step();
    stat_events = '0;
    step();
    check("oor_c3", cnt_of(3), 64'd0);
    check("oor_c2", cnt_of(2), 64'd51);

    // Disable holds, re-enable resumes.
    cfg_en[2] = 1'b0;
    stat_events = '1;
    repeat (20) step();
    stat_events = '0;
    step();
    check("dis_c2", cnt_of(2), 64'd51);
    cfg_en[2] = 1'b1;
    stat_events[1] = 1'b1;
    repeat (5) step();
    stat_events = '0;
    step();
    check("reen_c2", cnt_of(2), 64'd56);

    // All counters share the top event bit.
    for (int i = 0; i < N_CNT; i++) set_sel(i, N_EVT - 1);
    cfg_en  = '1;
    cfg_sat = '0;
    live_clear();
    total = 0;
    for (int k = 0; k < 200; k++) begin
      b = 1'($urandom_range(0, 1));
      stat_events[N_EVT-1] = b;
      total += int'(b);
      step();
    end
    stat_events = '0;
    step();
    step();
    for (int i = 0; i < N_CNT; i++) check("shared_cnt", cnt_of(i), 64'(total));
    regs_sa_snap = 1'b1;
    step();
    regs_sa_snap = 1'b0;
    step();
    for (int i = 0; i < N_CNT; i++) check("shared_shot", shot_of(i), 64'(total));
    step();

    // Reset coincident with a snap request wipes everything; no late strobe.
    regs_sa_snap = 1'b1;
    rst = 1'b1;
    step();
    regs_sa_snap = 1'b0;
    check("rmid_count", 64'(sa_count), 64'd0);
    check("rmid_snapshot", 64'(sa_snapshot), 64'd0);
    check("rmid_ovf", 64'(sa_ovf), 64'd0);
    check("rmid_vld", 64'(sa_snap_vld), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rmid_no_vld", 64'(sa_snap_vld), 64'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/cr_sa_core_param.md
Name: cr_sa_core_param

Overview:
- Parametrised statistics-accumulator core.
- N_CNT independent counters. Each counter selects one bit of a wide, concatenated stat-event bus, with per-counter enable and overflow mode.
- Supports a global snapshot and a global live-clear. The two may be combined for a lossless snap-and-clear.
- Sits between the per-block stat_events buses (cg, hufd, lz77, osf, isf, prefix, ...) and the stats regfile. It is the successor to the fixed 64 x 50-bit accumulator and adds sticky overflow, saturate/wrap mode and a snapshot-valid strobe.

Parameters:
- N_CNT, 64, number of counters.
- CNT_W, 50, counter width in bits.
- N_EVT, 512, width of the concatenated event bus.
- SEL_W, 9, width of the per-counter event selector; must satisfy 2**SEL_W >= N_EVT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stat_events  in  N_EVT  concatenated single-cycle event pulses.
- cfg_sel  in  N_CNT*SEL_W  per-counter event index; counter i uses slice [i*SEL_W +: SEL_W].
- cfg_en  in  N_CNT  per-counter count enable.
- cfg_sat  in  N_CNT  per-counter mode: 1 = saturate, 0 = wrap.
- regs_sa_snap  in  1  single-cycle snapshot request.
- regs_sa_clear_live  in  1  single-cycle live-counter clear.
- sa_count  out  N_CNT*CNT_W  live counter values.
- sa_snapshot  out  N_CNT*CNT_W  snapshot values.
- sa_ovf  out  N_CNT  sticky live overflow flags.
- sa_snap_ovf  out  N_CNT  overflow flags captured at the last snapshot.
- sa_snap_vld  out  1  one-cycle pulse: snapshot registers have been updated.

Behaviour:
- Clocking and reset: all state is on clk with synchronous active-high rst. While rst = 1 at a rising edge, every counter, snapshot, ovf, snap_ovf, sa_snap_vld and the event pipeline register go to 0. Reset asserted mid-count discards all accumulated values; no partial state survives.
- Stage 1: stat_events, regs_sa_snap and regs_sa_clear_live are registered together (evt_q, snap_q, clr_q). Because they share the stage, their relative cycle alignment is preserved.
- Stage 2, per counter i:
  - inc_i = cfg_en[i] & (cfg_sel_i < N_EVT) & evt_q[cfg_sel_i].
  - A selector that is out of range never counts.
- Latency: an event at cycle t is visible on sa_count at cycle t+2. The cfg_* inputs are sampled at stage 2 and are quasi-static; a change takes effect on the next counted event.
- Live update, per counter; priority order:
  - clr_q = 1: count <= {0, inc_i} and ovf <= 0. An event coincident with the clear is counted, not lost.
  - Otherwise, if inc_i = 1 and count != all-ones: count <= count + 1.
  - inc_i = 1 at all-ones with cfg_sat = 1: count holds all-ones and ovf <= 1.
  - inc_i = 1 at all-ones with cfg_sat = 0: count <= 0 and ovf <= 1.
  - Otherwise count holds.
- Snapshot:
  - snap_q = 1: every snapshot <= the current count (the value before this cycle's increment or clear), and snap_ovf <= the current ovf.
  - sa_snap_vld = 1 in the cycle after snap_q, i.e. request at t gives the strobe at t+2.
- Simultaneous snap and clear:
  - The snapshot gets the pre-clear totals.
  - The live counter restarts at inc_i.
  - Every event is therefore counted exactly once across the snapshot/live boundary.
- Back-to-back snaps: each one updates the snapshot registers and pulses sa_snap_vld; the pulses are not merged.
- Arithmetic: the increment is unsigned CNT_W-bit. There is no multi-bit increment; one event is at most +1 per cycle per counter.
- Several counters may select the same event bit; each counts independently.

Decomposition:
- Package cr_sa_paramPKG holds:
  - default constants SA_N_CNT, SA_CNT_W, SA_N_EVT, SA_SEL_W;
  - enum sa_mode_e {SA_WRAP = 0, SA_SAT = 1};
  - struct sa_cnt_cfg_t {sel, en, sat}, used by the regfile to pack cfg_*.
- Sub-module cr_sa_counter (one counter):
  - Inputs: clk, rst, inc, clr, snap, sat.
  - Outputs: count, snapshot, ovf, snap_ovf.
  - Instantiated N_CNT times in a generate loop.
- The top level holds stage 1, the per-counter event muxes and the sa_snap_vld register.

Test Plan:
- Reset/latency: rst for 2 cycles; then stat_events[5] pulses at cycle 10 with cfg_sel_0 = 5, cfg_en_0 = 1 -> all outputs 0 during reset; sa_count_0 = 1 at cycle 12, 0 at cycle 11.
- Saturate vs wrap: CNT_W = 4; counter 0 sat, counter 1 wrap; both select bit 0; 17 consecutive event pulses -> count0 = 15 with ovf0 = 1; count1 = 1 with ovf1 = 1; ovf1 first set on the 16th event.
- Snap+clear coincident with an event: count = 100; snap, clear and the selected event asserted in the same cycle -> snapshot = 100, count = 1, sa_snap_vld pulses 2 cycles later, ovf = 0.
- Selector and enable edge cases: cfg_sel = N_EVT + 3, all events high for 50 cycles -> count stays 0; cfg_en = 0 -> count holds its value; cfg_en re-enabled -> counting resumes without glitch.
- Shared and all-counter selection: all 64 counters select bit 511; 1000 random pulses on bit 511 -> every counter equals the pulse total; a snap then yields 64 identical snapshots.
- Reset mid-operation: counters at random nonzero values, rst asserted coincident with snap -> snapshot, count, ovf and sa_snap_vld are all 0 the cycle after reset; no sa_snap_vld pulse appears afterwards.
